fetch_queue: RTL

- Fetch stage of the OTTER pipeline, directly upstream of the IF/DE pipeline register and decode.
- Owns the fetch PC and issues reads to the synchronous instruction port of OTTER memory (registered read, 1-cycle latency).
- Buffers returned {PC, IR} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Redirects from execute (jump/taken branch) flush the FIFO and discard any in-flight read.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: execute redirect, instruction memory port and decode handshake.
// master = fetch_queue side, slave = environment (memory, execute, decode).
interface fetch_queue_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic                 REDIRECT;
  logic [DATAWIDTH-1:0] REDIRECT_PC;
  logic                 IMEM_RDEN;
  logic [13:0]          IMEM_ADDR;
  logic [DATAWIDTH-1:0] IMEM_DATA;
  logic                 DE_VALID;
  logic [DATAWIDTH-1:0] DE_PC;
  logic [DATAWIDTH-1:0] DE_IR;
  logic                 DE_READY;

  modport master (
    input  REDIRECT, REDIRECT_PC, IMEM_DATA, DE_READY,
    output IMEM_RDEN, IMEM_ADDR, DE_VALID, DE_PC, DE_IR
  );

  modport slave (
    output REDIRECT, REDIRECT_PC, IMEM_DATA, DE_READY,
    input  IMEM_RDEN, IMEM_ADDR, DE_VALID, DE_PC, DE_IR
  );
endinterface

// File: rtl/fetch_queue.sv
// OTTER fetch stage: owns the fetch PC, issues synchronous IMEM reads and queues {PC, IR} for decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic          CLK,
  input  logic          RESET_N,
  fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATAWIDTH-1:0] pc;
    logic [DATAWIDTH-1:0] ir;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [DATAWIDTH-1:0] fetch_pc;
  logic [DATAWIDTH-1:0] inflight_pc;
  logic                 inflight;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;

  logic [CNT_W:0]       occ_c;
  logic                 issue_c;
  logic                 resp_c;
  logic                 head_c;
  logic                 bypass_c;
  logic                 pop_c;
  logic                 push_c;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue credit counts queued plus in-flight entries; a same-cycle pop is not credited.
  always_comb begin
    occ_c    = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
    issue_c  = RESET_N & ~bus.REDIRECT & (occ_c < (CNT_W+1)'(DEPTH));
    resp_c   = inflight & ~bus.REDIRECT;
    head_c   = (count != '0);
`ifdef FETCH_BYPASS_EN
    bypass_c = resp_c & ~head_c;
`else
    bypass_c = 1'b0;
`endif
    pop_c    = head_c & bus.DE_READY;
    push_c   = RESET_N & resp_c & ~(bypass_c & bus.DE_READY);
  end

  always_comb begin
    bus.IMEM_RDEN = issue_c;
    bus.IMEM_ADDR = fetch_pc[15:2];
    bus.DE_VALID  = RESET_N & (head_c | bypass_c);
    bus.DE_PC     = '0;
    bus.DE_IR     = '0;
    if (RESET_N && head_c) begin
      bus.DE_PC = mem[rd_ptr].pc;
      bus.DE_IR = mem[rd_ptr].ir;
    end else if (RESET_N && bypass_c) begin
      bus.DE_PC = inflight_pc;
      bus.DE_IR = bus.IMEM_DATA;
    end
  end

  // Control state; reset beats redirect, redirect flushes queue and in-flight read.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.REDIRECT) begin
      fetch_pc    <= bus.REDIRECT_PC & ~DATAWIDTH'(3);
      inflight    <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + DATAWIDTH'(4);
      end
      if (push_c) wr_ptr <= ptr_next(wr_ptr);
      if (pop_c)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only observed below count.
  always_ff @(posedge CLK) begin
    if (push_c) mem[wr_ptr] <= '{pc: inflight_pc, ir: bus.IMEM_DATA};
  end

endmodule
